// File: rtl/smem_responder.sv
// smem_responder: shared data memory serving NUM_CORES load/store clients one at a time, round-robin.
// Optional macro SMEM_STATS_EN adds saturating completed-load/store counters.
module smem_responder #(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 8,
   parameter int LATENCY   = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_CORES-1:0]          req_ld,
   input  logic [NUM_CORES-1:0]          req_st,
   input  logic [NUM_CORES*ADDR_W-1:0]   addr,
   input  logic [NUM_CORES*DATA_W-1:0]   st_data,
   output logic [NUM_CORES-1:0]          val_data,
   output logic [DATA_W-1:0]             ld_data,
   output logic                          busy,
   output logic [15:0]                   ld_count,
   output logic [15:0]                   st_count
);
   localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t               state_r;
   logic [IDX_W-1:0]     rr_r;
   logic [IDX_W-1:0]     grant_r;
   logic [NUM_CORES-1:0] lock_r;
   logic [NUM_CORES-1:0] val_data_r;
   logic                 op_ld_r;
   logic [ADDR_W-1:0]    addr_r;
   logic [DATA_W-1:0]    data_r;
   logic [DATA_W-1:0]    ld_data_r;
   logic [CNT_W-1:0]     cnt_r;
   logic                 busy_r;
   logic [DATA_W-1:0]    mem_r [DEPTH];

   logic [NUM_CORES-1:0] elig_s;
   logic                 pick_valid_s;
   logic [IDX_W-1:0]     pick_idx_s;
   int unsigned          cand_s;
   logic                 access_s;
   logic                 mem_we_s;

   // Round-robin search: scanning offsets high to low leaves the eligible core nearest rr_r+1.
   always_comb begin
      elig_s       = (req_ld | req_st) & ~lock_r;
      pick_valid_s = |elig_s;
      pick_idx_s   = '0;
      cand_s       = 32'd0;
      for (int k = NUM_CORES - 32'sd1; k >= 32'sd0; k--) begin
         cand_s     = (32'(rr_r) + 32'(k) + 32'd1) % 32'(NUM_CORES);
         pick_idx_s = elig_s[cand_s[IDX_W-1:0]] ? cand_s[IDX_W-1:0] : pick_idx_s;
      end
   end

   assign access_s = (state_r == ACCESS) && (cnt_r == '0);
   // A store still pending when reset arrives must never reach the array.
   assign mem_we_s = access_s && !op_ld_r && !reset;

   // Arbitration, per-core locks, access sequencing and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         rr_r       <= IDX_W'(NUM_CORES - 1);
         grant_r    <= '0;
         lock_r     <= '0;
         op_ld_r    <= 1'b0;
         addr_r     <= '0;
         data_r     <= '0;
         cnt_r      <= '0;
         val_data_r <= '0;
         ld_data_r  <= '0;
         busy_r     <= 1'b0;
      end else begin
         // busy_r doubles as "grant_r is live", so the served core keeps its lock until back in IDLE.
         for (int i = 0; i < NUM_CORES; i++) begin
            if (!req_ld[i] && !req_st[i] && !(busy_r && (grant_r == IDX_W'(i)))) begin
               lock_r[i] <= 1'b0;
            end
         end
         val_data_r <= '0;
         case (state_r)
            IDLE: begin
               if (pick_valid_s) begin
                  grant_r            <= pick_idx_s;
                  rr_r               <= pick_idx_s;
                  lock_r[pick_idx_s] <= 1'b1;
                  op_ld_r            <= req_ld[pick_idx_s];
                  addr_r             <= addr[pick_idx_s*ADDR_W +: ADDR_W];
                  data_r             <= st_data[pick_idx_s*DATA_W +: DATA_W];
                  cnt_r              <= CNT_W'(LATENCY - 1);
                  busy_r             <= 1'b1;
                  state_r            <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt_r != '0) begin
                  cnt_r <= cnt_r - 1'b1;
               end else begin
                  if (op_ld_r) begin
                     ld_data_r <= mem_r[addr_r];
                  end
                  val_data_r <= NUM_CORES'(1'b1) << grant_r;
                  state_r    <= RESP;
               end
            end
            RESP: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Data array: deliberately unreset so contents survive a reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[addr_r] <= data_r;
      end
   end

`ifdef SMEM_STATS_EN
   logic [15:0] ld_count_r;
   logic [15:0] st_count_r;

   // Completion counters, bumped once per response and pinned at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         ld_count_r <= 16'h0000;
         st_count_r <= 16'h0000;
      end else if (state_r == RESP) begin
         if (op_ld_r && (ld_count_r != 16'hFFFF)) begin
            ld_count_r <= ld_count_r + 16'd1;
         end
         if (!op_ld_r && (st_count_r != 16'hFFFF)) begin
            st_count_r <= st_count_r + 16'd1;
         end
      end
   end

   assign ld_count = ld_count_r;
   assign st_count = st_count_r;
`else
   assign ld_count = 16'h0000;
   assign st_count = 16'h0000;
`endif

   assign val_data = val_data_r;
   assign ld_data  = ld_data_r;
   assign busy     = busy_r;

endmodule

// File: tb/tb_smem_responder.sv
// Bench for smem_responder: two instances (LATENCY 1 and 3) checked every cycle against a
// transaction-timing model, plus directed literal expectations.
`timescale 1ns/1ps
module tb_smem_responder;
   localparam int NC = 4;
`ifdef SMEM_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NC-1:0]    t_req_ld  [2];
   logic [NC-1:0]    t_req_st  [2];
   logic [NC*12-1:0] t_addr    [2];
   logic [NC*8-1:0]  t_st_data [2];
   logic [NC-1:0]    o_val  [2];
   logic [7:0]       o_ld   [2];
   logic             o_busy [2];
   logic [15:0]      o_ldc  [2];
   logic [15:0]      o_stc  [2];

   always #5 clk = ~clk;

   smem_responder #(.NUM_CORES(NC), .ADDR_W(12), .DATA_W(8), .LATENCY(1)) dut (
      .clk(clk), .reset(reset), .req_ld(t_req_ld[0]), .req_st(t_req_st[0]),
      .addr(t_addr[0]), .st_data(t_st_data[0]), .val_data(o_val[0]), .ld_data(o_ld[0]),
      .busy(o_busy[0]), .ld_count(o_ldc[0]), .st_count(o_stc[0]));

   smem_responder #(.NUM_CORES(NC), .ADDR_W(12), .DATA_W(8), .LATENCY(3)) dut3 (
      .clk(clk), .reset(reset), .req_ld(t_req_ld[1]), .req_st(t_req_st[1]),
      .addr(t_addr[1]), .st_data(t_st_data[1]), .val_data(o_val[1]), .ld_data(o_ld[1]),
      .busy(o_busy[1]), .ld_count(o_ldc[1]), .st_count(o_stc[1]));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   // Model: memory image, in-flight transaction with absolute response cycle, locks, rr pointer.
   logic [7:0]    m_mem [2][4096];
   int            lat [2] = '{1, 3};
   bit            m_ok [2];
   bit            m_fl [2];
   int            m_g [2];
   bit            m_ld [2];
   int            m_a [2];
   logic [7:0]    m_d [2];
   int            m_resp [2];
   bit [NC-1:0]   m_lock [2];
   int            m_rr [2];
   logic [NC-1:0] e_val [2];
   logic [7:0]    e_ld [2];
   bit            e_busy [2];
   int            e_ldc [2];
   int            e_stc [2];
   int            pulse_cyc [2][NC];
   int            pulse_cnt [2][NC];
   bit            sticky [2][NC];

   task automatic check(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d cyc %0d: got 0x%0h, expected 0x%0h", name, u, cyc, act, exp);
      end
   endtask

   // Advance the model from cycle cyc to cyc+1 using the inputs present now.
   task automatic model_step(input int u);
      int c;
      c = cyc;
      if (reset) begin
         m_ok[u] = 1'b1; m_fl[u] = 1'b0; m_lock[u] = '0; m_rr[u] = NC - 1;
         e_val[u] = '0; e_busy[u] = 1'b0; e_ld[u] = 8'h00; e_ldc[u] = 0; e_stc[u] = 0;
      end else if (m_ok[u]) begin
         for (int i = 0; i < NC; i++)
            if (!t_req_ld[u][i] && !t_req_st[u][i] && !(m_fl[u] && m_g[u] == i)) m_lock[u][i] = 1'b0;
         if (m_fl[u] && c == m_resp[u]) begin
            if (m_ld[u]) e_ldc[u] = (e_ldc[u] < 65535) ? e_ldc[u] + 1 : 65535;
            else         e_stc[u] = (e_stc[u] < 65535) ? e_stc[u] + 1 : 65535;
            m_fl[u] = 1'b0;
         end else if (!m_fl[u]) begin
            for (int k = 1; k <= NC; k++) begin
               int i;
               i = (m_rr[u] + k) % NC;
               if (!m_fl[u] && (t_req_ld[u][i] || t_req_st[u][i]) && !m_lock[u][i]) begin
                  m_fl[u] = 1'b1; m_g[u] = i; m_ld[u] = t_req_ld[u][i];
                  m_a[u] = int'(t_addr[u][i*12 +: 12]); m_d[u] = t_st_data[u][i*8 +: 8];
                  m_resp[u] = c + lat[u] + 1; m_lock[u][i] = 1'b1; m_rr[u] = i;
               end
            end
         end
         if (m_fl[u] && c + 1 == m_resp[u]) begin
            if (m_ld[u]) e_ld[u] = m_mem[u][m_a[u]];
            else         m_mem[u][m_a[u]] = m_d[u];
         end
         e_busy[u] = m_fl[u];
         e_val[u]  = (m_fl[u] && c + 1 == m_resp[u]) ? (NC'(1) << m_g[u]) : '0;
      end
   endtask

   // Compare process: check outputs of this cycle, log pulses, then step the model.
   initial begin
      for (int u = 0; u < 2; u++)
         for (int a = 0; a < 4096; a++) m_mem[u][a] = 8'h00;
      forever begin
         @(negedge clk);
         for (int u = 0; u < 2; u++) begin
            if (m_ok[u]) begin
               check("val_data", u, 32'(o_val[u]), 32'(e_val[u]));
               check("busy", u, 32'(o_busy[u]), 32'(e_busy[u]));
               check("ld_data", u, 32'(o_ld[u]), 32'(e_ld[u]));
               check("ld_count", u, 32'(o_ldc[u]), STATS ? 32'(e_ldc[u]) : 32'd0);
               check("st_count", u, 32'(o_stc[u]), STATS ? 32'(e_stc[u]) : 32'd0);
            end
            for (int i = 0; i < NC; i++)
               if (o_val[u][i] === 1'b1) begin
                  pulse_cyc[u][i] = cyc;
                  pulse_cnt[u][i]++;
               end
            model_step(u);
         end
      end
   end

   // One cycle: inputs change 2ns after the edge; cores drop a request once their pulse shows.
   task automatic tick();
      @(posedge clk);
      #2;
      for (int u = 0; u < 2; u++)
         for (int i = 0; i < NC; i++)
            if (o_val[u][i] === 1'b1 && !sticky[u][i]) begin
               t_req_ld[u][i] = 1'b0;
               t_req_st[u][i] = 1'b0;
            end
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic req(input int u, input int core, input bit ld, input logic [11:0] a, input logic [7:0] d);
      t_addr[u][core*12 +: 12] = a;
      t_st_data[u][core*8 +: 8] = d;
      t_req_ld[u][core] = ld;
      t_req_st[u][core] = !ld;
   endtask

   int t;
   int pc;

   initial begin
      for (int u = 0; u < 2; u++) begin
         t_req_ld[u] = '0; t_req_st[u] = '0; t_addr[u] = '0; t_st_data[u] = '0;
      end
      reset = 1'b1;
      ticks(3);
      reset = 1'b0;
      tick();
      check("reset_busy", 0, 32'(o_busy[0]), 32'd0);
      check("reset_val", 0, 32'(o_val[0]), 32'd0);

      // Store then load of the same address from a different core.
      req(0, 0, 1'b0, 12'h0A5, 8'h3C); t = cyc; ticks(4);
      check("st_pulse_time", 0, 32'(pulse_cyc[0][0]), 32'(t + 2));
      req(0, 2, 1'b1, 12'h0A5, 8'h00); t = cyc; ticks(4);
      check("ld_pulse_time", 0, 32'(pulse_cyc[0][2]), 32'(t + 2));
      check("ld_value_3c", 0, 32'(o_ld[0]), 32'h3C);

      // All four store together, then a reset puts rr back before all four load together.
      for (int i = 0; i < NC; i++) req(0, i, 1'b0, 12'h100 + 12'(i), 8'hC0 + 8'(i));
      ticks(14);
      reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 0; i < NC; i++) req(0, i, 1'b1, 12'h100 + 12'(i), 8'h00);
      t = cyc; ticks(14);
      for (int i = 0; i < NC; i++)
         check("rr_order", i, 32'(pulse_cyc[0][i]), 32'(t + 2 + 3 * i));
      check("rr_last_ld", 0, 32'(o_ld[0]), 32'hC3);

      // Sticky request: held long after its pulse, served once; drop one cycle to re-arm.
      sticky[0][1] = 1'b1; pc = pulse_cnt[0][1];
      req(0, 1, 1'b1, 12'h101, 8'h00); t = cyc; ticks(13);
      check("sticky_first", 0, 32'(pulse_cyc[0][1]), 32'(t + 2));
      check("sticky_once", 0, 32'(pulse_cnt[0][1]), 32'(pc + 1));
      t_req_ld[0][1] = 1'b0; tick();
      t_req_ld[0][1] = 1'b1; t = cyc; ticks(4);
      check("sticky_rearm", 0, 32'(pulse_cyc[0][1]), 32'(t + 2));
      check("sticky_twice", 0, 32'(pulse_cnt[0][1]), 32'(pc + 2));
      sticky[0][1] = 1'b0; t_req_ld[0][1] = 1'b0; tick();

      // LATENCY=3 instance at the top address.
      req(1, 3, 1'b0, 12'hFFF, 8'hA7); t = cyc; ticks(6);
      check("lat3_st_time", 1, 32'(pulse_cyc[1][3]), 32'(t + 4));
      req(1, 3, 1'b1, 12'hFFF, 8'h00); t = cyc; ticks(6);
      check("lat3_ld_time", 1, 32'(pulse_cyc[1][3]), 32'(t + 4));
      check("lat3_ld_a7", 1, 32'(o_ld[1]), 32'hA7);

      // Reset during ACCESS aborts the store and its pulse.
      req(0, 0, 1'b0, 12'h010, 8'h00); ticks(4);
      req(0, 0, 1'b0, 12'h010, 8'h55); tick();
      check("midop_busy", 0, 32'(o_busy[0]), 32'd1);
      pc = pulse_cnt[0][0];
      reset = 1'b1; t_req_st[0][0] = 1'b0; tick(); reset = 1'b0;
      check("midop_idle", 0, 32'(o_busy[0]), 32'd0);
      ticks(3);
      check("midop_no_pulse", 0, 32'(pulse_cnt[0][0]), 32'(pc));
      req(0, 0, 1'b1, 12'h010, 8'h00); ticks(4);
      check("midop_not_written", 0, 32'(o_ld[0]), 32'h00);

      // Three loads and two stores on the LATENCY=3 instance since the last reset.
      req(1, 0, 1'b1, 12'hFFF, 8'h00); ticks(6);
      req(1, 1, 1'b0, 12'h001, 8'h5A); ticks(6);
      req(1, 2, 1'b1, 12'h001, 8'h00); ticks(6);
      check("stats_ld_5a", 1, 32'(o_ld[1]), 32'h5A);
      req(1, 3, 1'b0, 12'h002, 8'h6B); ticks(6);
      req(1, 0, 1'b1, 12'h002, 8'h00); ticks(6);
      check("stats_ld_6b", 1, 32'(o_ld[1]), 32'h6B);
      check("stats_ld_count", 1, 32'(o_ldc[1]), STATS ? 32'd3 : 32'd0);
      check("stats_st_count", 1, 32'(o_stc[1]), STATS ? 32'd2 : 32'd0);
      ticks(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
